ks0108_bus_writer: RTL

Downstream timing stage for the dual-controller 128x64 graphic LCD panel. It receives command and data bytes from the pattern/page sequencer over a valid/ready handshake. It generates the divided-rate LCD bus write cycle on the panel pins (ENABLE, RW, DI, CS1, CS2, DATA). It also owns panel power-up: LCD_RST pulse plus the display-on and start-line commands to both controllers.

---
 rtl/ks0108_bus_writer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ks0108_bus_writer.sv
// ks0108_bus_writer: write-only bus timing stage for a dual-controller
// 128x64 KS0108 graphic LCD. It owns panel power-up: an LCD_RST pulse
// followed by the display-on and start-line commands to both controllers.
// After power-up it accepts command/data bytes over a valid/ready handshake.
// Each byte becomes one SETUP/STROBE/HOLD bus cycle, and each phase is
// TICK_DIV clocks long.
//
// Ports:
//   CLK, RESET        clock, asynchronous active-low reset
//   REQ_VALID/READY   request handshake; READY is high only when idle and
//                     initialised
//   REQ_DI/CS/DATA    request payload, latched on the accepting edge
//   INIT_DONE         power-up sequence finished; stays high until reset
//   LCD_*             panel pins (E, R/W, D/I, CS1, CS2, RST, DB[7:0])
module ks0108_bus_writer #(
  parameter int unsigned TICK_DIV = 256,
  parameter int unsigned RST_HOLD = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_DI,
  input  logic [1:0] REQ_CS,
  input  logic [7:0] REQ_DATA,
  output logic       INIT_DONE,
  output logic       LCD_ENABLE,
  output logic       LCD_RW,
  output logic       LCD_DI,
  output logic       LCD_CS1,
  output logic       LCD_CS2,
  output logic       LCD_RST,
  output logic [7:0] LCD_DATA
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam int unsigned RH_W  = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [RH_W-1:0]  RH_LAST = RH_W'(RST_HOLD - 1);

  typedef enum logic [2:0] {
    S_RST_LOW,
    S_RST_WAIT,
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [RH_W-1:0]  rh_cnt_q;
  logic [1:0]       init_idx_q;
  logic             init_done_q;
  logic             en_q;
  logic             di_q;
  logic [1:0]       cs_q;
  logic [7:0]       data_q;
  logic             lcd_rst_q;
  logic             tick_c;
  logic             accept_c;
  logic [1:0]       init_nxt_c;

  // Power-up commands: display on (0x3F), then start line 0 (0xC0).
  // Each command goes to CS1 first, then to CS2.
  function automatic logic [7:0] init_data(input logic [1:0] idx);
    return idx[1] ? 8'hC0 : 8'h3F;
  endfunction

  function automatic logic [1:0] init_cs(input logic [1:0] idx);
    return idx[0] ? 2'b10 : 2'b01;
  endfunction

  assign tick_c     = (cnt_q == CNT_MAX);
  assign REQ_READY  = (state_q == S_IDLE) && init_done_q;
  assign accept_c   = REQ_VALID && REQ_READY;
  assign init_nxt_c = init_idx_q + 2'd1;

  // Phase timer. Restarting it on accept makes every user phase a full
  // TICK_DIV clocks long.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (accept_c || tick_c) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Power-up sequencing and the bus write cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= S_RST_LOW;
      rh_cnt_q    <= '0;
      init_idx_q  <= 2'd0;
      init_done_q <= 1'b0;
      en_q        <= 1'b0;
      di_q        <= 1'b0;
      cs_q        <= 2'b00;
      data_q      <= 8'h00;
      lcd_rst_q   <= 1'b0;
    end else begin
      case (state_q)
        S_RST_LOW: begin
          if (tick_c) begin
            if (rh_cnt_q == RH_LAST) begin
              lcd_rst_q <= 1'b1;
              state_q   <= S_RST_WAIT;
            end else begin
              rh_cnt_q <= rh_cnt_q + RH_W'(1);
            end
          end
        end
        S_RST_WAIT: begin
          if (tick_c) begin
            init_idx_q <= 2'd0;
            data_q     <= init_data(2'd0);
            cs_q       <= init_cs(2'd0);
            di_q       <= 1'b0;
            state_q    <= S_SETUP;
          end
        end
        S_IDLE: begin
          if (accept_c) begin
            data_q  <= REQ_DATA;
            cs_q    <= REQ_CS;
            di_q    <= REQ_DI;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (tick_c) begin
            en_q    <= 1'b1;
            state_q <= S_STROBE;
          end
        end
        S_STROBE: begin
          if (tick_c) begin
            en_q    <= 1'b0;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (tick_c) begin
            if (!init_done_q && (init_idx_q != 2'd3)) begin
              // The next power-up write follows directly with no idle gap.
              init_idx_q <= init_nxt_c;
              data_q     <= init_data(init_nxt_c);
              cs_q       <= init_cs(init_nxt_c);
              state_q    <= S_SETUP;
            end else begin
              // Chip selects drop when idle; DATA and DI keep their last value.
              init_done_q <= 1'b1;
              cs_q        <= 2'b00;
              state_q     <= S_IDLE;
            end
          end
        end
        default: begin
          state_q <= S_RST_LOW;
        end
      endcase
    end
  end

  assign INIT_DONE  = init_done_q;
  assign LCD_ENABLE = en_q;
  assign LCD_RW     = 1'b0;
  assign LCD_DI     = di_q;
  assign LCD_CS1    = cs_q[0];
  assign LCD_CS2    = cs_q[1];
  assign LCD_RST    = lcd_rst_q;
  assign LCD_DATA   = data_q;

endmodule
